// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the shared interval-counter arbiter.
// The rr_pick helper is sized for up to 8 requesters.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam int DEFAULT_CW = 5;

    // The search starts at ptr and wraps at nreq-1. If no request is set, ptr is returned.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  ptr,
        input int unsigned nreq
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % nreq;
            if ((i < nreq) && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// It maps a request vector and a priority pointer to a one-hot winner.
module rr_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   win_idx,
    output logic [NREQ-1:0] win_onehot,
    output logic            win_any
);

    assign win_any = |req;
    assign win_idx = IW'(rr_pick(8'(req), 3'(ptr), NREQ));

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_any && (win_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/counter_arbiter.sv
// Shares one CW-bit tenure counter among NREQ requesters using round-robin ownership.
// Every tenure is followed by at least one dead cycle, and each completed tenure raises a per-requester done.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = DEFAULT_CW,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [IW-1:0]     owner,
    output logic [CW-1:0]     count
);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] last_q,  last_d;
    logic            busy_q,  busy_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q,   len_d;

    logic [CW-1:0]   len_arr [NREQ];
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            win_any;
    logic [CW-1:0]   win_len;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*CW +: CW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .win_idx    (win_idx),
        .win_onehot (win_onehot),
        .win_any    (win_any)
    );

    assign win_len = len_arr[win_idx];

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        last_d  = '0;
        busy_d  = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = '0;
        len_d   = len_q;
        case (state_q)
            IDLE, REL: begin
                if (win_any) begin
                    state_d = RUN;
                    grant_d = win_onehot;
                    busy_d  = 1'b1;
                    owner_d = win_idx;
                    ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : IW'(win_idx + 1'b1);
                    len_d   = win_len;
                    last_d  = (win_len == '0) ? win_onehot : '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!req[owner_q] || (count_q == len_q)) begin
                    state_d = REL;
                end else begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                    count_d = count_q + 1'b1;
                    last_d  = ((count_q + 1'b1) == len_q) ? grant_q : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // last_q marks the final grant cycle. Gating it with the live request means a drop on that cycle counts as an abort.
    assign done  = last_q & req;
    assign grant = grant_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign count = count_q;

endmodule
